// File: rtl/ethernet_gmii_rx_frame_checker.sv
// ethernet_gmii_rx_frame_checker: delineates GMII frames, checks FCS/length, buffers bytes in a FWFT FIFO
// and posts a per-frame status word with good/bad frame counters.
module ethernet_gmii_rx_frame_checker #(
  parameter int fifo_els_p = 2048,
  parameter int max_frame_len_p = 1518,
  parameter int min_frame_len_p = 64
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  gmii_rxd_i,
  input  logic        gmii_rx_dv_i,
  input  logic        gmii_rx_er_i,
  output logic [7:0]  data_o,
  output logic        data_v_o,
  output logic        data_last_o,
  input  logic        data_yumi_i,
  output logic [15:0] status_o,
  output logic        status_v_o,
  input  logic        status_yumi_i,
  output logic        status_overrun_o,
  output logic [31:0] frames_ok_o,
  output logic [31:0] frames_bad_o
);
  localparam int aw = $clog2(fifo_els_p);
  localparam logic [10:0] max_l = 11'(max_frame_len_p);
  localparam logic [10:0] min_l = 11'(min_frame_len_p);
  localparam logic [31:0] residue = 32'hdebb20e3;
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  state_t state, state_n;
  logic [7:0] hold;
  logic hold_v, ovf, err, close;
  logic [10:0] len;
  logic [31:0] crc;
  logic [8:0] mem [fifo_els_p];
  logic [8:0] head;
  logic [aw:0] wp, rp;
  logic full, empty, byte_in, frame_end, sfd, wr_req, wr, rd, good;
  logic [15:0] st_n;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hedb88320 : 32'h0);
    return r;
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = gmii_rx_dv_i ? ((gmii_rxd_i == 8'h55) ? PRE : DROP) : IDLE;
      PRE:  state_n = !gmii_rx_dv_i ? IDLE : (gmii_rxd_i == 8'h55) ? PRE : (gmii_rxd_i == 8'hd5) ? DATA : DROP;
      DATA: state_n = gmii_rx_dv_i ? DATA : IDLE;
      DROP: state_n = gmii_rx_dv_i ? DROP : IDLE;
    endcase
  end

  // The held byte is pushed when its successor arrives, or with last=1 when dv drops.
  assign byte_in = (state == DATA) && gmii_rx_dv_i;
  assign frame_end = (state == DATA) && !gmii_rx_dv_i;
  assign sfd = (state == PRE) && gmii_rx_dv_i && (gmii_rxd_i == 8'hd5);
  assign wr_req = frame_end ? hold_v : (byte_in && hold_v && (len <= max_l));
  assign empty = (wp == rp);
  assign full = (wp[aw] != rp[aw]) && (wp[aw-1:0] == rp[aw-1:0]);
  assign wr = wr_req && !full;
  assign rd = data_yumi_i && !empty;
  assign head = mem[rp[aw-1:0]];
  assign data_v_o = !empty;
  assign data_o = empty ? 8'h0 : head[7:0];
  assign data_last_o = !empty && head[8];
  assign st_n = {len, crc == residue, len < min_l, len > max_l, ovf, err};
  assign good = st_n[4] && (st_n[3:0] == 4'h0);

  always_ff @(posedge clk_i) if (wr) mem[wp[aw-1:0]] <= {frame_end, hold};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      hold <= 8'h0;
      hold_v <= 1'b0;
      len <= 11'h0;
      crc <= '1;
      ovf <= 1'b0;
      err <= 1'b0;
      close <= 1'b0;
      wp <= '0;
      rp <= '0;
      status_o <= 16'h0;
      status_v_o <= 1'b0;
      status_overrun_o <= 1'b0;
      frames_ok_o <= 32'h0;
      frames_bad_o <= 32'h0;
    end else begin
      state <= state_n;
      close <= frame_end;
      wp <= wp + (aw+1)'(wr);
      rp <= rp + (aw+1)'(rd);
      if (sfd) begin
        hold_v <= 1'b0;
        len <= 11'h0;
        crc <= '1;
        ovf <= 1'b0;
        err <= 1'b0;
      end else begin
        if (byte_in) begin
          hold <= gmii_rxd_i;
          hold_v <= 1'b1;
          len <= len + 11'(len != 11'h7ff);
          crc <= crc_step(crc, gmii_rxd_i);
        end
        if (wr_req && full) ovf <= 1'b1;
        if ((state == DATA) && gmii_rx_er_i) err <= 1'b1;
      end
      if (close) begin
        status_o <= st_n;
        status_v_o <= 1'b1;
        if (status_v_o && !status_yumi_i) status_overrun_o <= 1'b1;
        if (good) frames_ok_o <= frames_ok_o + 32'd1;
        else frames_bad_o <= frames_bad_o + 32'd1;
      end else if (status_yumi_i) status_v_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ethernet_gmii_rx_frame_checker.sv
// tb_ethernet_gmii_rx_frame_checker: directed frames with a byte/status scoreboard and a decoupled monitor.
module tb_ethernet_gmii_rx_frame_checker;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] rxd = 8'h0;
  logic dv = 1'b0, er = 1'b0;
  logic [7:0] data;
  logic data_v, data_last, data_yumi, status_v, status_yumi, overrun;
  logic [15:0] status;
  logic [31:0] ok, bad;
  logic ready = 1'b1, sready = 1'b1;
  int checks = 0, fails = 0, e_ok = 0, e_bad = 0;
  logic [8:0] exp_d[$];
  logic [15:0] exp_s[$];
  logic [7:0] fb[$];
  logic [15:0] last_st;

  always #4 clk = ~clk;
  assign data_yumi = ready & data_v;
  assign status_yumi = sready & status_v;

  ethernet_gmii_rx_frame_checker #(.fifo_els_p(64)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .gmii_rxd_i(rxd), .gmii_rx_dv_i(dv), .gmii_rx_er_i(er),
    .data_o(data), .data_v_o(data_v), .data_last_o(data_last), .data_yumi_i(data_yumi),
    .status_o(status), .status_v_o(status_v), .status_yumi_i(status_yumi),
    .status_overrun_o(overrun), .frames_ok_o(ok), .frames_bad_o(bad));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    if (data_v && ready) begin
      if (exp_d.size() == 0) begin
        checks++; fails++;
        $display("FAIL byte: unexpected byte %0h last %0b", data, data_last);
      end else check("byte", 32'({data_last, data}), 32'(exp_d.pop_front()));
    end
    if (status_v && sready) begin
      if (exp_s.size() == 0) begin
        checks++; fails++;
        $display("FAIL status: unexpected status %0h", status);
      end else check("status", 32'(status), 32'(exp_s.pop_front()));
    end
  end

  function automatic logic [31:0] crc_b(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
    return r;
  endfunction

  task automatic build(input int n, input int base);
    logic [31:0] c = '1;
    fb.delete();
    for (int i = 0; i < n - 4; i++) begin
      fb.push_back(8'(i + base));
      c = crc_b(c, 8'(i + base));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
  endtask

  task automatic expect_frame(input logic crc_ok, input logic ovf, input logic err, input int nwrite, input bit push_st);
    int n = fb.size();
    int w = 0;
    int l = (n > 2047) ? 2047 : n;
    for (int i = 0; i < n; i++)
      if ((i < 1518 || i == n - 1) && w < nwrite) begin
        exp_d.push_back({i == n - 1, fb[i]});
        w++;
      end
    last_st = {11'(l), crc_ok, n < 64, n > 1518, ovf, err};
    if (push_st) exp_s.push_back(last_st);
    if (crc_ok && !(n < 64) && !(n > 1518) && !ovf && !err) e_ok++; else e_bad++;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    @(posedge clk); #1;
    dv = v; rxd = d; er = e;
  endtask

  task automatic send(input int er_at);
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 7) ? 8'hd5 : 8'h55, 1'b0);
    for (int i = 0; i < fb.size(); i++) drive(1'b1, fb[i], i == er_at);
    drive(1'b0, 8'h0, 1'b0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_d.size() != 0 || exp_s.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++; fails++;
      $display("FAIL wait_idle: timeout, %0d bytes %0d statuses pending", exp_d.size(), exp_s.size());
      exp_d.delete();
      exp_s.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name);
    check({name, " ok"}, ok, 32'(e_ok));
    check({name, " bad"}, bad, 32'(e_bad));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset data_v", 32'(data_v), 0);
    check("reset data_last", 32'(data_last), 0);
    check("reset status_v", 32'(status_v), 0);
    check("reset status", 32'(status), 0);
    check("reset overrun", 32'(overrun), 0);
    check_counts("reset");
    reset_n = 1'b1;
    build(64, 0); expect_frame(1, 0, 0, 1 << 20, 1); send(-1); wait_idle(); check_counts("good64");
    build(64, 0); fb[63] ^= 8'h01; expect_frame(0, 0, 0, 1 << 20, 1); send(-1); wait_idle(); check_counts("badfcs");
    build(40, 7); expect_frame(1, 0, 0, 1 << 20, 1); send(-1); wait_idle(); check_counts("runt");
    build(1600, 3); expect_frame(1, 0, 0, 1 << 20, 1); send(-1); wait_idle(); check_counts("oversize");
    build(64, 11); expect_frame(1, 0, 1, 1 << 20, 1); send(20); wait_idle(); check_counts("rx_err");
    drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h13, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0);
    drive(1'b0, 8'h0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("drop data_v", 32'(data_v), 0);
    check("drop status_v", 32'(status_v), 0);
    check_counts("drop");
    build(64, 5); expect_frame(1, 0, 0, 1 << 20, 1); send(-1);
    build(70, 9); expect_frame(1, 0, 0, 1 << 20, 1); send(-1); wait_idle(); check_counts("ifg0");
    ready = 1'b0;
    build(100, 1); expect_frame(1, 1, 0, 64, 1); send(-1);
    repeat (10) @(posedge clk);
    #1;
    check("overflow status drained", 32'(exp_s.size()), 0);
    check("overflow held", 32'(data_v), 1);
    ready = 1'b1;
    wait_idle(); check_counts("overflow");
    sready = 1'b0;
    build(64, 2); expect_frame(1, 0, 0, 1 << 20, 0); send(-1);
    build(64, 3); expect_frame(1, 0, 0, 1 << 20, 0); send(-1);
    repeat (4) @(posedge clk);
    #1;
    check("overrun flag", 32'(overrun), 1);
    check("overrun status", 32'(status), 32'(last_st));
    exp_s.push_back(last_st);
    sready = 1'b1;
    wait_idle(); check_counts("overrun");
    ready = 1'b0;
    build(64, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, (i == 7) ? 8'hd5 : 8'h55, 1'b0);
    for (int i = 0; i < 30; i++) drive(1'b1, fb[i], 1'b0);
    #2 reset_n = 1'b0;
    dv = 1'b0;
    e_ok = 0; e_bad = 0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    check("post-reset data_v", 32'(data_v), 0);
    check("post-reset overrun", 32'(overrun), 0);
    ready = 1'b1;
    build(64, 4); expect_frame(1, 0, 0, 1 << 20, 1); send(-1); wait_idle(); check_counts("after reset");
    check("final bytes pending", 32'(exp_d.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ethernet_gmii_rx_frame_checker.md
Name: ethernet_gmii_rx_frame_checker

Overview:
- Consumes the byte-wide GMII stream recovered from the tethered CPU's RGMII transmit pins (after the DDR input stage) and delineates Ethernet frames.
- Strips preamble/SFD, checks FCS and length, and buffers frame bytes in a FIFO toward the bench's packet scoreboard.
- Posts a per-frame status word and running good/bad frame counters.

Parameters:
- fifo_els_p, 2048, byte FIFO depth; power of two, at least 64.
- max_frame_len_p, 1518, largest legal frame in bytes (DA through FCS).
- min_frame_len_p, 64, smallest legal frame in bytes (DA through FCS).

Ports:
- clk_i  in  1  GMII receive clock (125 MHz); the only clock.
- reset_n_i  in  1  asynchronous active-low reset.
- gmii_rxd_i  in  8  receive byte.
- gmii_rx_dv_i  in  1  data valid.
- gmii_rx_er_i  in  1  receive error.
- data_o  out  8  frame byte (DA first, FCS included).
- data_v_o  out  1  data_o valid.
- data_last_o  out  1  final byte of the frame.
- data_yumi_i  in  1  consumer takes the byte; legal only while data_v_o=1.
- status_o  out  16  {len[10:0], crc_ok, runt, oversize, overflow, rx_err}.
- status_v_o  out  1  status_o valid.
- status_yumi_i  in  1  consumer takes the status.
- status_overrun_o  out  1  sticky; set when an unconsumed status is overwritten.
- frames_ok_o  out  32  count of frames with all error bits clear; wraps.
- frames_bad_o  out  32  count of frames with any error bit set; wraps.

Behaviour:
- Reset is asynchronous active-low and applies to all flops. On reset: state=IDLE, FIFO empty, data_v_o=0, data_last_o=0, status_v_o=0, status_o=0, status_overrun_o=0, both counters=0.
- Reset asserted mid-frame discards the partial frame. No status is posted.
- FSM:
  - IDLE: dv&&rxd==0x55 -> PRE. dv with any other byte -> DROP.
  - PRE: rxd==0x55 stays in PRE. rxd==0xD5 -> DATA. Any other byte -> DROP. dv falling -> IDLE with no status.
  - DATA: every byte with dv=1 is a frame byte. dv falling -> IDLE and the frame closes.
  - DROP: waits for dv=0 -> IDLE. No bytes are written and no status is posted.
- Last-byte marking: one-byte hold register. Each new frame byte pushes the previously held byte to the FIFO with last=0. When dv falls, the held byte is pushed with last=1. FIFO entries are 9 bits (byte + last).
- FIFO write rules:
  - A write that finds the FIFO full is dropped and sets the frame's overflow bit.
  - If the last=1 write is the one dropped, the previous stored byte is not retro-marked. The consumer detects the dropped tail through the overflow bit.
  - Bytes beyond max_frame_len_p are not written and set the oversize bit. The final byte is still written with last=1.
- Length counter: 11 bits, saturating at 2047. It counts DA through FCS, including bytes that were not written.
- CRC-32: reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated over every DATA byte including the FCS. crc_ok=1 iff the register equals 0xDEBB20E3 after the last byte.
- Error bits:
  - runt = len < min_frame_len_p.
  - rx_err = gmii_rx_er_i seen at any DATA cycle.
- Status timing: status_o/status_v_o are registered one cycle after the last-byte push, i.e. 2 cycles after dv falls. frames_ok_o or frames_bad_o increments in that same cycle.
- Status handshake:
  - status_v_o holds until status_yumi_i.
  - If a new status arrives while status_v_o=1 with no yumi, the new status overwrites the old one and status_overrun_o is set (cleared only by reset).
  - If yumi and a new status coincide, the new status is loaded and status_v_o stays 1.
- Data handshake: data_o/data_last_o are FIFO head, first-word-fall-through. data_v_o = !empty. Simultaneous read and write while full is not permitted: the write is dropped as above.
- Back-to-back frames: IDLE accepts a new preamble the cycle after dv falls. A minimum IFG of zero must work.

Test Plan:
- 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS, consumer always ready -> 64 bytes out, last on byte 64, status len=64 crc_ok=1 all errors 0, frames_ok_o=1.
- Same frame with one FCS bit flipped -> crc_ok=0, frames_bad_o=1, 64 bytes still delivered.
- 40-byte frame with valid FCS -> runt=1; 1600-byte frame -> oversize=1, len=1600, 1518 bytes + final byte (1519 total) delivered with last on the final byte.
- fifo_els_p=64, consumer stalled, 100-byte frame -> overflow=1, exactly 64 entries held, len=100. Two frames with status never consumed -> status_overrun_o=1, status shows the second frame.
- Preamble 0x55,0x55,0x13 -> DROP, no output. gmii_rx_er_i pulsed mid-payload -> rx_err=1. Two good frames with zero IFG -> two statuses, frames_ok_o=2.
- reset_n_i asserted asynchronously at payload byte 30, released, then a good frame -> only the second frame appears; counters read 1/0.
